// File: rtl/inv_scheduler.sv
// Round-robin front end that serialises two requesters onto one modular-inverse
// engine, with a per-job cycle budget and a response held until consumed.
module inv_scheduler #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*WIDTH-1:0] req_e,
   input  logic [2*WIDTH-1:0] req_phi,
   output logic [1:0]         rsp_valid,
   input  logic [1:0]         rsp_ready,
   output logic [WIDTH-1:0]   rsp_d,
   output logic               rsp_ok,
   output logic               rsp_timeout,
   output logic               eng_start,
   output logic [WIDTH-1:0]   eng_e,
   output logic [WIDTH-1:0]   eng_phi,
   input  logic               eng_done,
   input  logic [WIDTH-1:0]   eng_d,
   input  logic               eng_d_valid
);

   localparam int CW = $clog2(TIMEOUT);
   // The counter leaves WAIT on the cycle it would step to TIMEOUT-1, so it never wraps.
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 2);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_rr;
   logic             r_owner;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_eng_e;
   logic [WIDTH-1:0] r_eng_phi;
   logic [WIDTH-1:0] r_rsp_d;
   logic             r_rsp_ok;
   logic             r_rsp_timeout;

   logic             w_grant;
   logic             w_accept;
   logic             w_done_take;
   logic             w_timeout_take;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode, arbitration and handshake outputs
   always_comb begin
      w_state_nxt    = r_state;
      w_grant        = r_rr;
      w_accept       = 1'b0;
      w_done_take    = 1'b0;
      w_timeout_take = 1'b0;
      req_ready      = 2'b00;
      rsp_valid      = 2'b00;
      eng_start      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid[r_rr]) begin
               w_grant = r_rr;
            end else begin
               w_grant = ~r_rr;
            end
            if (req_valid != 2'b00) begin
               w_accept    = 1'b1;
               req_ready   = w_grant ? 2'b10 : 2'b01;
               w_state_nxt = ST_ISSUE;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            eng_start   = 1'b1;
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            // A done in the final budget cycle beats the timeout.
            if (eng_done) begin
               w_done_take = 1'b1;
               w_state_nxt = ST_RESP;
            end else if (r_cnt == CNT_LAST) begin
               w_timeout_take = 1'b1;
               w_state_nxt    = ST_RESP;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_RESP: begin
            rsp_valid = r_owner ? 2'b10 : 2'b01;
            if (rsp_ready[r_owner]) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_RESP;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Job bookkeeping: operands, owner, round-robin pointer, budget counter, result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_rr          <= 1'b0;
         r_owner       <= 1'b0;
         r_cnt         <= '0;
         r_eng_e       <= '0;
         r_eng_phi     <= '0;
         r_rsp_d       <= '0;
         r_rsp_ok      <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         if (w_accept) begin
            r_eng_e   <= w_grant ? req_e[2*WIDTH-1:WIDTH]   : req_e[WIDTH-1:0];
            r_eng_phi <= w_grant ? req_phi[2*WIDTH-1:WIDTH] : req_phi[WIDTH-1:0];
            r_owner   <= w_grant;
            r_rr      <= ~w_grant;
         end
         case (r_state)
            ST_ISSUE: r_cnt <= '0;
            ST_WAIT:  r_cnt <= r_cnt + CW'(1);
            default:  r_cnt <= r_cnt;
         endcase
         if (w_done_take) begin
            r_rsp_d       <= eng_d_valid ? eng_d : '0;
            r_rsp_ok      <= eng_d_valid;
            r_rsp_timeout <= 1'b0;
         end else if (w_timeout_take) begin
            r_rsp_d       <= '0;
            r_rsp_ok      <= 1'b0;
            r_rsp_timeout <= 1'b1;
         end
      end
   end

   assign eng_e       = r_eng_e;
   assign eng_phi     = r_eng_phi;
   assign rsp_d       = r_rsp_d;
   assign rsp_ok      = r_rsp_ok;
   assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_inv_scheduler.sv
// Self-checking bench for inv_scheduler: the bench plays the inverse engine and
// predicts grants, latencies and responses from a transaction-level model.
module tb_inv_scheduler;

   localparam int W  = 16;
   localparam int TO = 8;

   logic           clk;
   logic           rst_n;
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [2*W-1:0] req_e;
   logic [2*W-1:0] req_phi;
   logic [1:0]     rsp_valid;
   logic [1:0]     rsp_ready;
   logic [W-1:0]   rsp_d;
   logic           rsp_ok;
   logic           rsp_timeout;
   logic           eng_start;
   logic [W-1:0]   eng_e;
   logic [W-1:0]   eng_phi;
   logic           eng_done;
   logic [W-1:0]   eng_d;
   logic           eng_d_valid;

   int   n_run  = 0;
   int   n_fail = 0;
   logic m_rr;

   inv_scheduler #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_e(req_e), .req_phi(req_phi),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_d(rsp_d), .rsp_ok(rsp_ok), .rsp_timeout(rsp_timeout),
      .eng_start(eng_start), .eng_e(eng_e), .eng_phi(eng_phi),
      .eng_done(eng_done), .eng_d(eng_d), .eng_d_valid(eng_d_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: a job's engine budget is TIMEOUT-1 waiting cycles after the start cycle.
   function automatic logic m_tmo(input int dl);
      return !(dl >= 1 && dl <= TO - 1);
   endfunction

   // Model: cycles from eng_start to the first rsp_valid.
   function automatic int m_lat(input int dl);
      if (!m_tmo(dl)) return dl + 1;
      return TO;
   endfunction

   // Model: contention goes to the round-robin favourite, a lone requester always wins.
   function automatic int m_grant(input logic [1:0] mask, input logic rr);
      if (mask == 2'b11) return rr ? 1 : 0;
      return mask[1] ? 1 : 0;
   endfunction

   // Model: packed expected response {rsp_valid, rsp_d, rsp_ok, rsp_timeout}.
   function automatic logic [W+3:0] m_rsp(input int g, input int dl, input logic [W-1:0] d, input logic dv);
      logic t;
      t = m_tmo(dl);
      return {(g == 1) ? 2'b10 : 2'b01, (t || !dv) ? {W{1'b0}} : d, !t && dv, t};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; eng_done = 1'b0;
      tick; tick;
      rst_n = 1'b1;
      m_rr  = 1'b0;
   endtask

   // Drives one job from IDLE through release, acting as the engine; records observations only.
   task automatic do_job(input logic [1:0] mask, input logic [W-1:0] e0, input logic [W-1:0] p0,
                         input logic [W-1:0] e1, input logic [W-1:0] p1, input int dl,
                         input logic [W-1:0] dres, input logic dv, input int rdy,
                         output int g, output int ta, output int ts, output int tr,
                         output logic [W+3:0] rsp, output int bad);
      logic rel;
      g = -1; ta = -1; ts = -1; tr = -1; rsp = '0; bad = 0; rel = 1'b0;
      req_e = {e1, e0}; req_phi = {p1, p0}; req_valid = mask;
      eng_d = dres; eng_d_valid = dv;
      for (int cyc = 0; cyc < 200 && !rel; cyc++) begin
         eng_done  = (ts >= 0 && dl > 0 && cyc == ts + dl);
         rsp_ready = 2'($urandom_range(0, 3));
         #1;
         if (g < 0) begin
            if (req_ready != 2'b00) begin
               if ((req_ready != 2'b01 && req_ready != 2'b10) || (req_ready & ~mask) != 2'b00) bad++;
               g  = req_ready[1] ? 1 : 0;
               ta = cyc;
            end
         end else begin
            if (req_ready != 2'b00) bad++;
            if (cyc > ta && (eng_e !== (g == 1 ? e1 : e0) || eng_phi !== (g == 1 ? p1 : p0))) bad++;
         end
         if (eng_start === 1'b1) begin
            if (ts >= 0) bad++;
            else ts = cyc;
         end
         if (rsp_valid != 2'b00) begin
            if (tr < 0) begin
               tr  = cyc;
               rsp = {rsp_valid, rsp_d, rsp_ok, rsp_timeout};
            end else if ({rsp_valid, rsp_d, rsp_ok, rsp_timeout} !== rsp) begin
               bad++;
            end
            if (g >= 0 && cyc >= tr + rdy) begin
               rsp_ready[g] = 1'b1;
               rel = 1'b1;
            end else if (g >= 0) begin
               rsp_ready[g] = 1'b0;
            end
         end
         @(posedge clk);
         #1;
         if (g >= 0) req_valid[g] = 1'b0;
      end
      eng_done  = 1'b0;
      rsp_ready = 2'b00;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; eng_done = 1'b0;
      req_e = '1; req_phi = '1; eng_d = '1; eng_d_valid = 1'b1;
      tick; tick;
      n_run++;
      if ({req_ready, rsp_valid, rsp_d, rsp_ok, rsp_timeout, eng_start, eng_e, eng_phi} !== '0) begin
         n_fail++;
         $display("FAIL reset_values got rr=%b rv=%b d=%h ok=%b to=%b st=%b e=%h phi=%h want all zero",
                  req_ready, rsp_valid, rsp_d, rsp_ok, rsp_timeout, eng_start, eng_e, eng_phi);
      end
      rst_n = 1'b1; req_valid = 2'b11;
      #1;
      n_run++;
      if (req_ready !== 2'b01) begin
         n_fail++; $display("FAIL reset_first_grant got %b want 01", req_ready);
      end
      req_valid = 2'b00;
      tick;
      m_rr = 1'b0;
   endtask

   task automatic test_known;
      int g, ta, ts, tr, bad;
      logic [W+3:0] rsp;
      logic [W+3:0] ex;
      do_job(2'b01, W'(17), W'(3120), W'(0), W'(0), 5, W'(2753), 1'b1, 0, g, ta, ts, tr, rsp, bad);
      ex = {2'b01, W'(2753), 1'b1, 1'b0};
      n_run++;
      if (g !== 0 || ts - ta !== 1 || tr - ts !== 6) begin
         n_fail++; $display("FAIL known_r0_timing got g=%0d start=+%0d rsp=+%0d want g=0 +1 +6", g, ts - ta, tr - ts);
      end
      n_run++;
      if (rsp !== ex || bad !== 0) begin
         n_fail++; $display("FAIL known_r0_rsp got %h bad=%0d want %h bad=0", rsp, bad, ex);
      end
      m_rr = 1'b1;
      do_job(2'b10, W'(0), W'(0), W'(6), W'(3120), 3, W'(520), 1'b0, 1, g, ta, ts, tr, rsp, bad);
      ex = {2'b10, W'(0), 1'b0, 1'b0};
      n_run++;
      if (g !== 1 || ta !== 0 || rsp !== ex || bad !== 0) begin
         n_fail++; $display("FAIL known_r1_rsp got g=%0d acc=%0d rsp=%h bad=%0d want g=1 acc=0 rsp=%h bad=0",
                            g, ta, rsp, bad, ex);
      end
      m_rr = 1'b0;
   endtask

   task automatic test_contention;
      int g, ta, ts, tr, bad, ge;
      logic [W+3:0] rsp;
      logic [1:0] masks [3];
      masks = '{2'b11, 2'b10, 2'b11};
      do_reset;
      for (int i = 0; i < 3; i++) begin
         ge = m_grant(masks[i], m_rr);
         do_job(masks[i], W'(101), W'(200), W'(303), W'(400), 2, W'(55 + i), 1'b1, 0, g, ta, ts, tr, rsp, bad);
         n_run++;
         if (g !== ge || ta !== 0 || rsp !== m_rsp(ge, 2, W'(55 + i), 1'b1) || bad !== 0) begin
            n_fail++; $display("FAIL contention_%0d got g=%0d acc=%0d rsp=%h bad=%0d want g=%0d acc=0 rsp=%h",
                               i, g, ta, rsp, bad, ge, m_rsp(ge, 2, W'(55 + i), 1'b1));
         end
         m_rr = (ge == 0);
      end
      req_valid = 2'b00;
   endtask

   task automatic test_timeout;
      int g, ta, ts, tr, bad, ge;
      logic [W+3:0] rsp;
      logic [W-1:0] dres;
      int dls [5];
      int rds [5];
      dls = '{0, TO + 1, TO - 1, TO, 2};
      rds = '{2, 3, 0, 1, 0};
      for (int i = 0; i < 5; i++) begin
         ge   = (i % 2 == 0) ? 0 : 1;
         dres = W'($urandom);
         do_job((ge == 1) ? 2'b10 : 2'b01, W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                dls[i], dres, 1'b1, rds[i], g, ta, ts, tr, rsp, bad);
         n_run++;
         if (g !== ge || ts - ta !== 1 || tr - ts !== m_lat(dls[i])) begin
            n_fail++; $display("FAIL timeout_timing_%0d got g=%0d start=+%0d rsp=+%0d want g=%0d +1 +%0d",
                               i, g, ts - ta, tr - ts, ge, m_lat(dls[i]));
         end
         n_run++;
         if (rsp !== m_rsp(ge, dls[i], dres, 1'b1) || bad !== 0) begin
            n_fail++; $display("FAIL timeout_rsp_%0d got %h bad=%0d want %h", i, rsp, bad, m_rsp(ge, dls[i], dres, 1'b1));
         end
         m_rr = (ge == 0);
      end
   endtask

   task automatic test_reset_wait;
      int g, ta, ts, tr, bad, seen;
      logic [W+3:0] rsp;
      req_e = {W'(0), W'(23)}; req_phi = {W'(0), W'(99)}; req_valid = 2'b01;
      eng_done = 1'b0; rsp_ready = 2'b00; eng_d = W'(77); eng_d_valid = 1'b1;
      tick;
      req_valid = 2'b00;
      tick; tick; tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1; eng_done = 1'b1;
      #1;
      n_run++;
      if ({req_ready, rsp_valid, rsp_d, rsp_ok, rsp_timeout, eng_start, eng_e, eng_phi} !== '0) begin
         n_fail++;
         $display("FAIL reset_wait_values got rr=%b rv=%b d=%h ok=%b to=%b st=%b e=%h phi=%h want all zero",
                  req_ready, rsp_valid, rsp_d, rsp_ok, rsp_timeout, eng_start, eng_e, eng_phi);
      end
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         tick;
         eng_done = 1'b0;
         if (rsp_valid != 2'b00 || eng_start !== 1'b0) seen++;
      end
      n_run++;
      if (seen !== 0) begin
         n_fail++; $display("FAIL reset_wait_quiet got %0d active cycles want 0", seen);
      end
      m_rr = 1'b0;
      do_job(2'b10, W'(0), W'(0), W'(9), W'(40), 1, W'(31), 1'b1, 0, g, ta, ts, tr, rsp, bad);
      n_run++;
      if (g !== 1 || ta !== 0 || tr - ta !== 3 || rsp !== m_rsp(1, 1, W'(31), 1'b1) || bad !== 0) begin
         n_fail++; $display("FAIL reset_wait_next got g=%0d acc=%0d lat=%0d rsp=%h bad=%0d want g=1 acc=0 lat=3 rsp=%h",
                            g, ta, tr - ta, rsp, bad, m_rsp(1, 1, W'(31), 1'b1));
      end
      m_rr = 1'b0;
   endtask

   task automatic test_hold;
      int g, ta, ts, tr, bad, ge;
      logic [W+3:0] rsp;
      ge = m_grant(2'b11, m_rr);
      do_job(2'b11, W'(11), W'(12), W'(13), W'(14), 4, W'(1234), 1'b1, 10, g, ta, ts, tr, rsp, bad);
      n_run++;
      if (g !== ge || rsp !== m_rsp(ge, 4, W'(1234), 1'b1) || bad !== 0) begin
         n_fail++; $display("FAIL hold_rsp got g=%0d rsp=%h bad=%0d want g=%0d rsp=%h bad=0",
                            g, rsp, bad, ge, m_rsp(ge, 4, W'(1234), 1'b1));
      end
      m_rr = (ge == 0);
      ge = 1 - ge;
      do_job((ge == 1) ? 2'b10 : 2'b01, W'(11), W'(12), W'(13), W'(14), 1, W'(5), 1'b1, 0, g, ta, ts, tr, rsp, bad);
      n_run++;
      if (g !== ge || ta !== 0 || bad !== 0) begin
         n_fail++; $display("FAIL hold_next_accept got g=%0d acc=%0d bad=%0d want g=%0d acc=0", g, ta, bad, ge);
      end
      m_rr = (ge == 0);
   endtask

   task automatic test_random;
      int g, ta, ts, tr, bad, ge, dl;
      logic [W+3:0] rsp;
      logic [W-1:0] oe [2];
      logic [W-1:0] op [2];
      logic [W-1:0] dres;
      logic [1:0] pend;
      logic [1:0] mask;
      logic dv;
      pend = 2'b00;
      for (int i = 0; i < 30; i++) begin
         mask = pend | 2'($urandom_range(1, 3));
         for (int r = 0; r < 2; r++) begin
            if (!pend[r]) begin
               oe[r] = W'($urandom); op[r] = W'($urandom);
            end
         end
         dl   = $urandom_range(0, TO + 2);
         dres = W'($urandom);
         dv   = 1'($urandom);
         ge   = m_grant(mask, m_rr);
         do_job(mask, oe[0], op[0], oe[1], op[1], dl, dres, dv, $urandom_range(0, 3),
                g, ta, ts, tr, rsp, bad);
         n_run++;
         if (g !== ge || ta !== 0 || ts - ta !== 1 || tr - ts !== m_lat(dl) ||
             rsp !== m_rsp(ge, dl, dres, dv) || bad !== 0) begin
            n_fail++; $display("FAIL random_%0d got g=%0d acc=%0d st=+%0d rsp=+%0d %h bad=%0d want g=%0d +1 +%0d %h",
                               i, g, ta, ts - ta, tr - ts, rsp, bad, ge, m_lat(dl), m_rsp(ge, dl, dres, dv));
         end
         m_rr = (ge == 0);
         pend = mask & ((ge == 1) ? 2'b01 : 2'b10);
      end
      req_valid = 2'b00;
      tick;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; eng_done = 1'b0;
      req_e = '0; req_phi = '0; eng_d = '0; eng_d_valid = 1'b0; m_rr = 1'b0;
      test_reset;
      test_known;
      test_contention;
      test_timeout;
      test_reset_wait;
      test_hold;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
